vga_rx: RTL and testbench

- VGA receiver/capture block, the receive-side counterpart of the team's VGA timing generator (vga_if).
- Samples a 4:4:4 RGB plus HS/VS stream on the pixel clock.
- Recovers the horizontal and vertical position, checks the line and frame timing against the parameters, and runs a lock FSM.
- Emits qualified active-area pixels with X/Y coordinates. Used for loopback verification of vga_if and for capture from an external source on the same pixel clock.

---
 rtl/vga_timing_pkg.sv | 29 ++
 rtl/vga_sync_edge.sv | 27 ++
 rtl/vga_rx.sv | 128 ++++++++++++
 tb/tb_vga_rx.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared VGA timing constants, totals and receiver lock states
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam bit DEF_HS_POL   = 1'b0;
  localparam bit DEF_VS_POL   = 1'b0;

  function automatic int hTotal(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int vTotal(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } rxState_t;

endpackage

// File: rtl/vga_sync_edge.sv
// rtl/vga_sync_edge.sv - sync polarity normalisation, input register and leading-edge detect
module vga_sync_edge #(
  parameter bit POL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sync,
  output logic lead
);

  logic level;
  logic prev;

  // prev resets low, so a sync already asserted at reset release reads as an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 1'b0;
      prev  <= 1'b0;
    end else begin
      level <= (sync == POL);
      prev  <= level;
    end
  end

  assign lead = level & ~prev;

endmodule

// File: rtl/vga_rx.sv
// rtl/vga_rx.sv - VGA capture: position recovery, timing checks, lock FSM, qualified pixel output
module vga_rx
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = DEF_HS_POL,
  parameter bit VS_POL   = DEF_VS_POL,
  parameter int CW       = 10
) (
  input  logic          clkIn,
  input  logic          rstIn,
  input  logic [3:0]    vgaRIn,
  input  logic [3:0]    vgaGIn,
  input  logic [3:0]    vgaBIn,
  input  logic          vgaHsIn,
  input  logic          vgaVsIn,
  output logic [3:0]    pixROut,
  output logic [3:0]    pixGOut,
  output logic [3:0]    pixBOut,
  output logic [CW-1:0] pixXOut,
  output logic [CW-1:0] pixYOut,
  output logic          pixValidOut,
  output logic          frameStartOut,
  output logic          lockedOut,
  output logic          errOut
);

  localparam int H_TOTAL = hTotal(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vTotal(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [11:0] H_LAST  = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_END   = 12'(H_TOTAL);
  localparam logic [11:0] H_START = 12'(H_SYNC + H_BP);
  localparam logic [11:0] H_STOP  = 12'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_END   = 11'(V_TOTAL);
  localparam logic [10:0] V_START = 11'(V_SYNC + V_BP);
  localparam logic [10:0] V_STOP  = 11'(V_SYNC + V_BP + V_ACTIVE - 1);

  logic        hsEdge;
  logic        vsEdge;
  logic [11:0] rgb1;
  logic [11:0] hCnt;
  logic [11:0] hNext;
  logic [10:0] vCnt;
  logic [10:0] vNext;
  logic        active;
  logic        violRaw;
  logic        viol;
  logic        pixOk;
  rxState_t    state;

  vga_sync_edge #(.POL(HS_POL)) hsSync (.clk(clkIn), .rst(rstIn), .sync(vgaHsIn), .lead(hsEdge));
  vga_sync_edge #(.POL(VS_POL)) vsSync (.clk(clkIn), .rst(rstIn), .sync(vgaVsIn), .lead(vsEdge));

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) rgb1 <= '0;
    else       rgb1 <= {vgaRIn, vgaGIn, vgaBIn};
  end

  // hNext/vNext are the coordinates of the pixel currently held in stage 1
  always_comb begin
    hNext   = hsEdge ? 12'd0 : ((hCnt == 12'hFFF) ? hCnt : hCnt + 12'd1);
    vNext   = vsEdge ? 11'd0 :
              (hsEdge ? ((vCnt == 11'h7FF) ? vCnt : vCnt + 11'd1) : vCnt);
    violRaw = (hsEdge && (hCnt != H_LAST)) || (hNext == H_END) ||
              (vsEdge && (vCnt != V_LAST)) || (vNext == V_END);
    viol    = (state != SEARCH) && violRaw;
    active  = (hNext >= H_START) && (hNext <= H_STOP) &&
              (vNext >= V_START) && (vNext <= V_STOP);
    pixOk   = (state == LOCKED) && !viol && active;
  end

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      state         <= SEARCH;
      hCnt          <= '0;
      vCnt          <= '0;
      lockedOut     <= 1'b0;
      errOut        <= 1'b0;
      pixValidOut   <= 1'b0;
      frameStartOut <= 1'b0;
      pixROut       <= '0;
      pixGOut       <= '0;
      pixBOut       <= '0;
      pixXOut       <= '0;
      pixYOut       <= '0;
    end else begin
      hCnt   <= hNext;
      vCnt   <= vNext;
      errOut <= viol;
      case (state)
        SEARCH: begin
          lockedOut <= 1'b0;
          if (vsEdge) state <= ACQUIRE;
        end
        ACQUIRE: begin
          lockedOut <= vsEdge && !viol;
          if (viol)        state <= SEARCH;
          else if (vsEdge) state <= LOCKED;
        end
        LOCKED: begin
          lockedOut <= !viol;
          if (viol) state <= SEARCH;
        end
        default: begin
          lockedOut <= 1'b0;
          state     <= SEARCH;
        end
      endcase
      pixValidOut   <= pixOk;
      frameStartOut <= pixOk && (hNext == H_START) && (vNext == V_START);
      pixROut       <= pixOk ? rgb1[11:8] : 4'd0;
      pixGOut       <= pixOk ? rgb1[7:4]  : 4'd0;
      pixBOut       <= pixOk ? rgb1[3:0]  : 4'd0;
      pixXOut       <= pixOk ? CW'(hNext - H_START) : '0;
      pixYOut       <= pixOk ? CW'(vNext - V_START) : '0;
    end
  end

endmodule

// File: tb/tb_vga_rx.sv
// tb/tb_vga_rx.sv - scoreboard bench for vga_rx on a reduced timing, both sync polarities
module tb_vga_rx;

  localparam int HA = 8, HF = 2, HSY = 3, HB = 3;
  localparam int VA = 6, VF = 1, VSY = 2, VB = 2;
  localparam int CW = 10;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int HS0 = HSY + HB;
  localparam int VS0 = VSY + VB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]    vgaR, vgaG, vgaB;
  logic          hs0, vs0, hs1, vs1;
  logic          pv[2], fs[2], lk[2], er[2];
  logic [3:0]    pr[2], pg[2], pb[2];
  logic [CW-1:0] px[2], py[2];

  vga_rx #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
           .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
           .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW)) dut0 (
    .clkIn(clk), .rstIn(rst), .vgaRIn(vgaR), .vgaGIn(vgaG), .vgaBIn(vgaB),
    .vgaHsIn(hs0), .vgaVsIn(vs0), .pixROut(pr[0]), .pixGOut(pg[0]), .pixBOut(pb[0]),
    .pixXOut(px[0]), .pixYOut(py[0]), .pixValidOut(pv[0]), .frameStartOut(fs[0]),
    .lockedOut(lk[0]), .errOut(er[0]));

  vga_rx #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
           .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
           .HS_POL(1'b1), .VS_POL(1'b1), .CW(CW)) dut1 (
    .clkIn(clk), .rstIn(rst), .vgaRIn(vgaR), .vgaGIn(vgaG), .vgaBIn(vgaB),
    .vgaHsIn(hs1), .vgaVsIn(vs1), .pixROut(pr[1]), .pixGOut(pg[1]), .pixBOut(pb[1]),
    .pixXOut(px[1]), .pixYOut(py[1]), .pixValidOut(pv[1]), .frameStartOut(fs[1]),
    .lockedOut(lk[1]), .errOut(er[1]));

  typedef struct {
    int          due;
    logic [33:0] v;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   nCmp = 0;
  int   nFail = 0;
  int   errCnt[2] = '{0, 0};
  int   errCyc[2] = '{-1, -1};
  int   lockCyc[2] = '{-1, -1};
  int   valCnt[2] = '{0, 0};
  int   fsCnt[2] = '{0, 0};
  logic errLk[2] = '{1'b0, 1'b0};
  logic prevLk[2] = '{1'b0, 1'b0};
  int   lineCyc = 0;
  int   frameCyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    logic [33:0] ev;
    logic [33:0] av;
    if (!rst) begin
      while (q.size() > 0 && q[0].due < cyc) begin
        nCmp++;
        nFail++;
        $display("FAIL missed_pixel due=%0d now=%0d expected=%h", q[0].due, cyc, q[0].v);
        void'(q.pop_front());
      end
      ev = '0;
      if (q.size() > 0 && q[0].due == cyc) ev = q.pop_front().v;
      for (int d = 0; d < 2; d++) begin
        av = {pv[d], pr[d], pg[d], pb[d], px[d], py[d], fs[d]};
        nCmp++;
        if (av !== ev) begin
          nFail++;
          $display("FAIL pixel_out dut%0d cyc=%0d got=%h expected=%h", d, cyc, av, ev);
        end
        if (pv[d] === 1'b1) valCnt[d]++;
        if (fs[d] === 1'b1) fsCnt[d]++;
        if (er[d] === 1'b1) begin
          errCnt[d]++;
          errCyc[d] = cyc;
          errLk[d]  = lk[d];
        end
        if (lk[d] === 1'b1 && prevLk[d] !== 1'b1) lockCyc[d] = cyc;
        prevLk[d] = lk[d];
      end
    end else begin
      prevLk[0] = 1'b0;
      prevLk[1] = 1'b0;
    end
  end

  task automatic drive(input logic hsA, input logic vsA, input logic [3:0] r,
                       input logic [3:0] g, input logic [3:0] b);
    @(posedge clk);
    #1;
    hs0 = ~hsA; hs1 = hsA; vs0 = ~vsA; vs1 = vsA;
    vgaR = r; vgaG = g; vgaB = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic genLine(input int len, input int ln, input bit push, input bit hsOn);
    logic [3:0]    r, g, b;
    logic [CW-1:0] x, y;
    bit            act;
    for (int h = 0; h < len; h++) begin
      act = (h >= HS0) && (h < HS0 + HA) && (ln >= VS0) && (ln < VS0 + VA);
      x = CW'(h - HS0);
      y = CW'(ln - VS0);
      r = act ? x[3:0] : 4'($urandom);
      g = act ? y[3:0] : 4'($urandom);
      b = act ? 4'(x[3:0] + y[3:0]) : 4'($urandom);
      drive(hsOn && (h < HSY), ln < VSY, r, g, b);
      if (h == 0) lineCyc = cyc;
      if (act && push) q.push_back('{due: cyc + 2, v: {1'b1, r, g, b, x, y, (x == 0) && (y == 0)}});
    end
  endtask

  task automatic genFrame(input int nLines, input bit push);
    for (int l = 0; l < nLines; l++) begin
      genLine(HT, l, push, 1'b1);
      if (l == 0) frameCyc = lineCyc;
    end
  endtask

  task automatic test_reset();
    hs0 = 1'b1; vs0 = 1'b1; hs1 = 1'b0; vs1 = 1'b0;
    vgaR = 4'd0; vgaG = 4'd0; vgaB = 4'd0;
    rst = 1'b1;
    idle(3);
    for (int d = 0; d < 2; d++) begin
      nCmp++;
      if ({pv[d], pr[d], pg[d], pb[d], px[d], py[d], fs[d], lk[d], er[d]} !== 36'd0) begin
        nFail++;
        $display("FAIL reset_outputs dut%0d got=%h expected=0", d,
                 {pv[d], pr[d], pg[d], pb[d], px[d], py[d], fs[d], lk[d], er[d]});
      end
    end
    rst = 1'b0;
    idle(4);
  endtask

  task automatic test_short_frame();
    int eb[2];
    int f2;
    for (int d = 0; d < 2; d++) begin eb[d] = errCnt[d]; lockCyc[d] = -1; end
    genFrame(VT - 1, 1'b0);
    genFrame(VT, 1'b0);
    f2 = frameCyc;
    for (int d = 0; d < 2; d++) begin
      nCmp++;
      if (errCnt[d] - eb[d] !== 1) begin nFail++; $display("FAIL short_frame_err_count dut%0d got=%0d expected=1", d, errCnt[d] - eb[d]); end
      nCmp++;
      if (errCyc[d] !== f2 + 2) begin nFail++; $display("FAIL short_frame_err_cycle dut%0d got=%0d expected=%0d", d, errCyc[d], f2 + 2); end
      nCmp++;
      if (lockCyc[d] !== -1 || errLk[d] !== 1'b0) begin nFail++; $display("FAIL short_frame_no_lock dut%0d got=%0d expected=-1", d, lockCyc[d]); end
    end
  endtask

  task automatic test_lock();
    int vb[2], fb[2], eb[2];
    int f2;
    for (int d = 0; d < 2; d++) begin eb[d] = errCnt[d]; lockCyc[d] = -1; end
    genFrame(VT, 1'b0);
    for (int d = 0; d < 2; d++) begin vb[d] = valCnt[d]; fb[d] = fsCnt[d]; end
    genFrame(VT, 1'b1);
    f2 = frameCyc;
    for (int d = 0; d < 2; d++) begin
      nCmp++;
      if (lockCyc[d] !== f2 + 2) begin nFail++; $display("FAIL lock_rise_cycle dut%0d got=%0d expected=%0d", d, lockCyc[d], f2 + 2); end
      nCmp++;
      if (valCnt[d] - vb[d] !== HA * VA) begin nFail++; $display("FAIL frame_valid_count dut%0d got=%0d expected=%0d", d, valCnt[d] - vb[d], HA * VA); end
    end
    genFrame(VT, 1'b1);
    for (int d = 0; d < 2; d++) begin
      nCmp++;
      if (fsCnt[d] - fb[d] !== 2) begin nFail++; $display("FAIL frame_start_count dut%0d got=%0d expected=2", d, fsCnt[d] - fb[d]); end
      nCmp++;
      if (errCnt[d] !== eb[d] || lk[d] !== 1'b1) begin nFail++; $display("FAIL lock_stable dut%0d got=err%0d/lk%0b expected=err%0d/lk1", d, errCnt[d], lk[d], eb[d]); end
    end
  endtask

  task automatic checkRelock(input string name, input int eb0, input int eb1, input int errExp);
    int f;
    for (int d = 0; d < 2; d++) lockCyc[d] = -1;
    genFrame(VT, 1'b0);
    genFrame(VT, 1'b1);
    f = frameCyc;
    for (int d = 0; d < 2; d++) begin
      nCmp++;
      if (lockCyc[d] !== f + 2) begin nFail++; $display("FAIL %s_relock dut%0d got=%0d expected=%0d", name, d, lockCyc[d], f + 2); end
      nCmp++;
      if (errCnt[d] - ((d == 0) ? eb0 : eb1) !== errExp) begin
        nFail++;
        $display("FAIL %s_err_count dut%0d got=%0d expected=%0d", name, d, errCnt[d] - ((d == 0) ? eb0 : eb1), errExp);
      end
    end
  endtask

  task automatic test_short_line();
    int eb[2];
    int bad;
    for (int d = 0; d < 2; d++) eb[d] = errCnt[d];
    for (int l = 0; l < VT; l++) begin
      genLine((l == 3) ? HT - 1 : HT, l, l < 3, 1'b1);
      if (l == 4) bad = lineCyc;
    end
    for (int d = 0; d < 2; d++) begin
      nCmp++;
      if (errCyc[d] !== bad + 2 || errLk[d] !== 1'b0) begin
        nFail++;
        $display("FAIL short_line_err dut%0d got=cyc%0d/lk%0b expected=cyc%0d/lk0", d, errCyc[d], errLk[d], bad + 2);
      end
    end
    checkRelock("short_line", eb[0], eb[1], 1);
  endtask

  task automatic test_missing_hs();
    int eb[2];
    int dead;
    for (int d = 0; d < 2; d++) eb[d] = errCnt[d];
    for (int l = 0; l < 5; l++) genLine(HT, l, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 1'b0, 4'($urandom), 4'($urandom), 4'($urandom));
      if (i == 0) dead = cyc;
    end
    for (int d = 0; d < 2; d++) begin
      nCmp++;
      if (errCyc[d] !== dead + 2 || errLk[d] !== 1'b0) begin
        nFail++;
        $display("FAIL missing_hs_err dut%0d got=cyc%0d/lk%0b expected=cyc%0d/lk0", d, errCyc[d], errLk[d], dead + 2);
      end
    end
    checkRelock("missing_hs", eb[0], eb[1], 1);
  endtask

  task automatic test_reset_midline();
    int eb[2];
    for (int l = 0; l < VS0; l++) genLine(HT, l, 1'b1, 1'b1);
    genLine(HS0 + 6, VS0, 1'b1, 1'b1);
    #1;
    for (int d = 0; d < 2; d++) begin
      nCmp++;
      if (pv[d] !== 1'b1 || px[d] !== CW'(3) || py[d] !== CW'(0)) begin
        nFail++;
        $display("FAIL midline_before_reset dut%0d got=v%0b x%0d y%0d expected=v1 x3 y0", d, pv[d], px[d], py[d]);
      end
    end
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      nCmp++;
      if ({pv[d], pr[d], pg[d], pb[d], px[d], py[d], fs[d], lk[d], er[d]} !== 36'd0) begin
        nFail++;
        $display("FAIL async_reset_outputs dut%0d got=%h expected=0", d,
                 {pv[d], pr[d], pg[d], pb[d], px[d], py[d], fs[d], lk[d], er[d]});
      end
    end
    q.delete();
    for (int d = 0; d < 2; d++) eb[d] = errCnt[d];
    idle(3);
    rst = 1'b0;
    idle(3);
    checkRelock("reset_midline", eb[0], eb[1], 0);
  endtask

  initial begin
    test_reset();
    test_short_frame();
    test_lock();
    test_short_line();
    test_missing_hs();
    test_reset_midline();
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
